nibble_serializer: RTL and testbench
====================================

Name: nibble_serializer

Overview:
- Parallel-in, serial-out transmitter for register words.
- Accepts one DATA_WIDTH-bit word per valid/ready handshake.
- Sends each word on a single line as a frame: start bit, data bits LSB first, optional even parity, stop bit.
- Sits downstream of the team's parallel-load data registers and drives a serial link to a matching deserializer.

Parameters:
- DATA_WIDTH, 4, number of data bits per frame (1..16).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).
- PARITY_EN, 1, 1 = insert even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- data_input  input  DATA_WIDTH  word to transmit.
- data_valid  input  1  data_input is valid.
- data_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial line, idles high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, serial_out=1, busy=0, done=0, data_ready=0.
  - Shift register and counters cleared.
  - Reset asserted mid-frame aborts the frame immediately; no done pulse is produced.
- data_ready = (state==IDLE) and reset deasserted. It is combinational from state.
- Handshake: a word is accepted on a rising edge where data_valid=1 and data_ready=1.
  - data_input is latched into a holding shift register.
  - data_input changes after acceptance have no effect.
  - data_valid while not ready is ignored and does not queue.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (PARITY_EN=1) or STOP (PARITY_EN=0) after DATA_WIDTH bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after one bit period.
- Line levels are registered outputs:
  - START: 0.
  - DATA: bit i, LSB first.
  - PARITY: XOR of all data bits (even parity).
  - STOP and IDLE: 1.
- Latency and timing:
  - serial_out drops to 0 in the first cycle after the accepting edge.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Frame length F = (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles.
- busy=1 in every state except IDLE.
- done=1 for exactly one cycle: the first IDLE cycle after STOP completes. data_ready is also 1 in that cycle.
- Back-to-back frames:
  - A word offered during the done cycle is accepted on that edge.
  - The line therefore spends exactly one extra high cycle between frames (stop bit + 1 idle cycle).
- Counters:
  - The bit-period counter is clog2(CLKS_PER_BIT)-wide, wraps from CLKS_PER_BIT-1 to 0, and advances the bit index on wrap.
  - The bit index is clog2(DATA_WIDTH+1)-wide.
  - CLKS_PER_BIT=1 must work, with one bit per cycle.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with data_valid=1 -> serial_out=1, data_ready=0, busy=0, done=0 throughout; no frame starts.
- Basic frame (defaults): accept 4'b1011 at edge k -> serial_out sequence 0,1,1,0,1,1,1, each bit held 4 cycles over k+1..k+28; done high in cycle k+29 only; busy high k+1..k+28.
- Back-to-back: offer 4'h5 then 4'hA continuously with data_valid=1 -> second start bit begins exactly 1 cycle after first stop bit ends; frames 0,1,0,1,0,0,1 and 0,0,1,0,1,0,1.
- Data stability: accept 4'h3, then drive data_input=4'hC and data_valid=1 during the frame -> transmitted bits remain 1,1,0,0 with parity 0; 4'hC is accepted only at the done cycle.
- Mid-frame reset: assert reset=0 asynchronously during the DATA state of 4'hF -> serial_out=1 immediately, no done pulse; after release, data_ready=1 and a new 4'h0 frame transmits 0,0,0,0,0,0,1.
- Parameter sweep: PARITY_EN=0, CLKS_PER_BIT=1, DATA_WIDTH=8, accept 8'hA5 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1; done in cycle 11.

Source files
------------

// File: rtl/nibble_serializer.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data bits,
// optional even parity, stop bit, each held CLKS_PER_BIT clock cycles.
module nibble_serializer #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      clk_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  parity_bit;
    logic                  line_next;
    logic                  done_next;
    logic                  accept;
    logic                  bit_end;
    logic                  last_bit;

    assign data_ready = (state == IDLE) && reset;
    assign accept     = data_ready && data_valid;
    assign busy       = (state != IDLE);
    assign bit_end    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_bit   = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign shifted    = shreg >> 1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Line level is computed one cycle ahead so serial_out is a clean register.
    always_comb begin
        state_next = state;
        line_next  = serial_out;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                line_next = 1'b1;
                if (accept) begin
                    state_next = START;
                    line_next  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    line_next  = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (!last_bit) begin
                        line_next = shifted[0];
                    end else if (PARITY_EN != 0) begin
                        state_next = PARITY;
                        line_next  = parity_bit;
                    end else begin
                        state_next = STOP;
                        line_next  = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    line_next  = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    line_next  = 1'b1;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            serial_out <= 1'b1;
            done       <= 1'b0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
        end else begin
            serial_out <= line_next;
            done       <= done_next;

            if (state == IDLE || bit_end) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + CNT_W'(1);
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            if (accept) begin
                shreg      <= data_input;
                parity_bit <= ^data_input;
            end else if (state == DATA && bit_end) begin
                shreg <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Randomized bench for nibble_serializer: two configurations driven in lockstep
// and compared every cycle against a frame-position reference model.
module tb_nibble_serializer;

    localparam int DW_A = 4, CPB_A = 4, PE_A = 1;
    localparam int DW_B = 8, CPB_B = 1, PE_B = 0;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [DW_A-1:0] data_a = '0;
    logic            valid_a = 1'b0;
    logic            ready_a, line_a, busy_a, done_a;
    logic [DW_B-1:0] data_b = '0;
    logic            valid_b = 1'b0;
    logic            ready_b, line_b, busy_b, done_b;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Model: pos = cycles since the accepting edge (0 = idle, no frame).
    int          pos_a = 0, pos_b = 0;
    logic [15:0] word_a = '0, word_b = '0;
    bit          acc_a, acc_b;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    nibble_serializer #(.DATA_WIDTH(DW_A), .CLKS_PER_BIT(CPB_A), .PARITY_EN(PE_A)) dut_a (
        .clock(clock), .reset(reset), .data_input(data_a), .data_valid(valid_a),
        .data_ready(ready_a), .serial_out(line_a), .busy(busy_a), .done(done_a)
    );

    nibble_serializer #(.DATA_WIDTH(DW_B), .CLKS_PER_BIT(CPB_B), .PARITY_EN(PE_B)) dut_b (
        .clock(clock), .reset(reset), .data_input(data_b), .data_valid(valid_b),
        .data_ready(ready_b), .serial_out(line_b), .busy(busy_b), .done(done_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(input int dw, input int cpb, input int pe);
        return (2 + dw + pe) * cpb;
    endfunction

    function automatic logic exp_line(input int pos, input logic [15:0] w,
                                      input int dw, input int cpb, input int pe);
        int  idx;
        logic p;
        if (pos < 1 || pos > frame_len(dw, cpb, pe)) return 1'b1;
        idx = (pos - 1) / cpb;
        if (idx == 0) return 1'b0;
        if (idx <= dw) return w[idx-1];
        if (pe != 0 && idx == dw + 1) begin
            p = 1'b0;
            for (int i = 0; i < dw; i++) p ^= w[i];
            return p;
        end
        return 1'b1;
    endfunction

    function automatic logic exp_ready(input int pos, input int f);
        return reset && (pos == 0 || pos == f + 1);
    endfunction

    task automatic advance(inout int pos, inout logic [15:0] w, output bit acc,
                           input logic valid, input logic [15:0] d,
                           input int dw, input int cpb, input int pe);
        int f;
        f   = frame_len(dw, cpb, pe);
        acc = 1'b0;
        if (!reset) begin
            pos = 0;
        end else if (exp_ready(pos, f) && valid) begin
            pos = 1;
            w   = d & ((16'd1 << dw) - 16'd1);
            acc = 1'b1;
        end else if (pos >= 1 && pos <= f) begin
            pos++;
        end else begin
            pos = 0;
        end
    endtask

    task automatic check_outputs();
        int fa, fb;
        fa = frame_len(DW_A, CPB_A, PE_A);
        fb = frame_len(DW_B, CPB_B, PE_B);
        check("a_line",  32'(line_a),  32'(exp_line(pos_a, word_a, DW_A, CPB_A, PE_A)));
        check("a_busy",  32'(busy_a),  32'(pos_a >= 1 && pos_a <= fa));
        check("a_done",  32'(done_a),  32'(pos_a == fa + 1));
        check("a_ready", 32'(ready_a), 32'(exp_ready(pos_a, fa)));
        check("b_line",  32'(line_b),  32'(exp_line(pos_b, word_b, DW_B, CPB_B, PE_B)));
        check("b_busy",  32'(busy_b),  32'(pos_b >= 1 && pos_b <= fb));
        check("b_done",  32'(done_b),  32'(pos_b == fb + 1));
        check("b_ready", 32'(ready_b), 32'(exp_ready(pos_b, fb)));
    endtask

    task automatic cycle();
        @(posedge clock);
        advance(pos_a, word_a, acc_a, valid_a, 16'(data_a), DW_A, CPB_A, PE_A);
        advance(pos_b, word_b, acc_b, valid_b, 16'(data_b), DW_B, CPB_B, PE_B);
        @(negedge clock);
        check_outputs();
    endtask

    // Offer queued words (with random valid gaps); random junk on data while idle.
    task automatic run(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            valid_a = (q_a.size() > 0) && ($urandom_range(99) >= gap_pct);
            data_a  = valid_a ? q_a[0][DW_A-1:0] : DW_A'($urandom);
            valid_b = (q_b.size() > 0) && ($urandom_range(99) >= gap_pct);
            data_b  = valid_b ? q_b[0][DW_B-1:0] : DW_B'($urandom);
            cycle();
            if (acc_a) void'(q_a.pop_front());
            if (acc_b) void'(q_b.pop_front());
        end
    endtask

    initial begin
        int guard;

        // Reset held with valid asserted: nothing may start.
        q_a.push_back(16'h7);
        q_b.push_back(16'h3C);
        @(negedge clock);
        check_outputs();
        run(3, 0);
        q_a.delete();
        q_b.delete();
        reset = 1'b1;
        run(2, 0);

        // Basic frame and parameter-sweep word.
        q_a.push_back(16'hB);
        q_b.push_back(16'hA5);
        run(34, 0);

        // Back-to-back, then data stability during a frame.
        q_a.push_back(16'h5);
        q_a.push_back(16'hA);
        q_a.push_back(16'h3);
        q_a.push_back(16'hC);
        q_b.push_back(16'h00);
        q_b.push_back(16'hFF);
        run(130, 0);

        // Mid-frame reset during DATA of 4'hF.
        q_a.push_back(16'hF);
        q_b.push_back(16'h81);
        guard = 0;
        while (pos_a != 10 && guard < 100) begin
            run(1, 0);
            guard++;
        end
        check("reach_data_timeout", 32'(pos_a), 32'd10);
        #2 reset = 1'b0;
        #1;
        pos_a = 0;
        pos_b = 0;
        q_a.delete();
        q_b.delete();
        check("rst_line", 32'(line_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ready", 32'(ready_a), 32'd0);
        @(negedge clock);
        check_outputs();
        run(2, 0);
        reset = 1'b1;
        q_a.push_back(16'h0);
        run(32, 0);

        // Random words with random valid gaps.
        for (int k = 0; k < 30; k++) begin
            q_a.push_back(16'($urandom_range(15)));
            q_b.push_back(16'($urandom_range(255)));
        end
        run(1100, 30);
        run(40, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
